// File: rtl/munoc_axi_burst_splitter_pkg.sv
// Shared AXI field widths and encodings, plus the splitter's FSM states and
// the 4KB page constants. The AXI defines carry an include guard so other
// munoc blocks can pull them in as well.
`ifndef MUNOC_AXI_DEFINES_SV
`define MUNOC_AXI_DEFINES_SV
`define BW_AXI_ALEN     8
`define BW_AXI_ASIZE    3
`define BW_AXI_ABURST   2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`endif

package munoc_axi_burst_splitter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam int unsigned PAGE_BYTES     = 4096;
    localparam int unsigned BW_PAGE_OFFSET = 12;
    localparam int unsigned BW_PAGE_SPAN   = BW_PAGE_OFFSET + 1;

endpackage

// File: rtl/munoc_axi_burst_splitter_beat_calc.sv
// munoc_burst_beat_calc: number of beats in the next burst.
// beats = min(remaining, MAX_BURST_LEN[, beats left in the current 4KB page])
// The page term is included only when MUNOC_BURST_SPLIT_4KB_EN is defined.
module munoc_burst_beat_calc
    import munoc_axi_burst_splitter_pkg::*;
#(
    parameter int BW_DATA       = 32,
    parameter int BW_LENGTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [BW_PAGE_OFFSET-1:0] page_offset,
    input  logic [BW_LENGTH-1:0]      remaining,
    output logic [BW_LENGTH-1:0]      beats
);

    localparam int          LOG2_BPB  = $clog2(BW_DATA / 8);
    localparam logic [31:0] MAX_BEATS = 32'(MAX_BURST_LEN);

`ifdef MUNOC_BURST_SPLIT_4KB_EN
    logic [BW_PAGE_SPAN-1:0] bytes_to_page;
    logic [31:0]             beats_to_page;

    // Distance to the next 4KB boundary; page_offset is beat aligned.
    assign bytes_to_page = BW_PAGE_SPAN'(PAGE_BYTES) - {1'b0, page_offset};
    assign beats_to_page = 32'(bytes_to_page >> LOG2_BPB);
`else
    logic unused_page_offset;
    assign unused_page_offset = ^page_offset;
`endif

    // Clamp the remaining beat count by each limit in turn.
    always_comb begin
        beats = remaining;
        if (32'(remaining) > MAX_BEATS) begin
            beats = BW_LENGTH'(MAX_BURST_LEN);
        end
`ifdef MUNOC_BURST_SPLIT_4KB_EN
        if (32'(beats) > beats_to_page) begin
            beats = BW_LENGTH'(beats_to_page);
        end
`endif
    end

endmodule

// File: rtl/munoc_axi_burst_splitter.sv
// munoc_axi_burst_splitter: turns a linear (address, byte count) request into
// a sequence of AXI INCR burst commands. Optional macro
// MUNOC_BURST_SPLIT_4KB_EN keeps every burst inside one 4KB page.
module munoc_axi_burst_splitter
    import munoc_axi_burst_splitter_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_LENGTH     = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BW_ADDR-1:0]        req_addr,
    input  logic [BW_LENGTH-1:0]      req_size,
    output logic [BW_ADDR-1:0]        axaddr,
    output logic [`BW_AXI_ALEN-1:0]   axlen,
    output logic [`BW_AXI_ASIZE-1:0]  axsize,
    output logic [`BW_AXI_ABURST-1:0] axburst,
    output logic                      axvalid,
    input  logic                      axready,
    output logic                      done
);

    localparam int                 BPB        = BW_DATA / 8;
    localparam int                 LOG2_BPB   = $clog2(BPB);
    localparam int                 BW_ALEN    = `BW_AXI_ALEN;
    localparam int                 BW_ASIZE   = `BW_AXI_ASIZE;
    localparam logic [BW_ADDR-1:0] ALIGN_MASK = BW_ADDR'(BPB - 1);

    state_t                    state;
    logic [BW_LENGTH-1:0]      remaining;
    logic [BW_LENGTH-1:0]      beats_q;
    logic [BW_ADDR-1:0]        req_addr_aligned;
    logic [BW_ADDR-1:0]        next_addr;
    logic [BW_LENGTH-1:0]      req_beats;
    logic [BW_LENGTH-1:0]      next_remaining;
    logic [BW_LENGTH-1:0]      calc_remaining;
    logic [BW_LENGTH-1:0]      calc_beats;
    logic [BW_PAGE_OFFSET-1:0] calc_offset;

    assign req_ready = (state == ST_IDLE);
    assign axvalid   = (state == ST_ISSUE);
    assign axsize    = BW_ASIZE'(LOG2_BPB);
    assign axburst   = `AXI_BURST_INCR;

    assign req_addr_aligned = req_addr & ~ALIGN_MASK;
    assign req_beats        = req_size >> LOG2_BPB;
    // Address arithmetic wraps modulo 2^BW_ADDR.
    assign next_addr        = axaddr + (BW_ADDR'(beats_q) << LOG2_BPB);
    assign next_remaining   = remaining - beats_q;

    // The calculator always sizes the burst about to be loaded: the new
    // request while idle, the follow-on burst while issuing.
    always_comb begin
        if (state == ST_IDLE) begin
            calc_offset    = req_addr_aligned[BW_PAGE_OFFSET-1:0];
            calc_remaining = req_beats;
        end else begin
            calc_offset    = next_addr[BW_PAGE_OFFSET-1:0];
            calc_remaining = next_remaining;
        end
    end

    munoc_burst_beat_calc #(
        .BW_DATA       (BW_DATA),
        .BW_LENGTH     (BW_LENGTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_beat_calc (
        .page_offset (calc_offset),
        .remaining   (calc_remaining),
        .beats       (calc_beats)
    );

    // Request/issue FSM with registered command fields and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            axaddr    <= '0;
            axlen     <= '0;
            remaining <= '0;
            beats_q   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (req_valid) begin
                    axaddr    <= req_addr_aligned;
                    remaining <= req_beats;
                    if (req_beats == '0) begin
                        done <= 1'b1;
                    end else begin
                        beats_q <= calc_beats;
                        axlen   <= BW_ALEN'(calc_beats - 1'b1);
                        state   <= ST_ISSUE;
                    end
                end
            end else begin
                if (axready) begin
                    if (next_remaining == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        axaddr    <= next_addr;
                        remaining <= next_remaining;
                        beats_q   <= calc_beats;
                        axlen     <= BW_ALEN'(calc_beats - 1'b1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_munoc_axi_burst_splitter.sv
// Testbench for munoc_axi_burst_splitter (BW_DATA=32, MAX_BURST_LEN=16).
module tb_munoc_axi_burst_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [15:0] req_size = '0;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
    logic        axvalid;
    logic        axready = 1'b0;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];

    munoc_axi_burst_splitter #(
        .BW_ADDR       (32),
        .BW_DATA       (32),
        .BW_LENGTH     (16),
        .MAX_BURST_LEN (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .axaddr    (axaddr),
        .axlen     (axlen),
        .axsize    (axsize),
        .axburst   (axburst),
        .axvalid   (axvalid),
        .axready   (axready),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference split: walk the byte range in plain arithmetic, 4 bytes/beat.
    task automatic model_split(input logic [31:0] a, input logic [15:0] s);
        longint unsigned addr;
        int unsigned     rem;
        int unsigned     b;
        addr = longint'(a) - (longint'(a) % 4);
        rem  = int'(s) / 4;
        while (rem > 0) begin
            b = (rem < 16) ? rem : 16;
`ifdef MUNOC_BURST_SPLIT_4KB_EN
            if (b > (4096 - (addr % 4096)) / 4) b = int'((4096 - (addr % 4096)) / 4);
`endif
            exp_addr_q.push_back(addr[31:0]);
            exp_len_q.push_back(8'(b - 1));
            addr = (addr + longint'(b) * 4) % 64'h1_0000_0000;
            rem  = rem - b;
        end
    endtask

    // Issue one request (expected bursts already queued) and follow it to done.
    task automatic run_req(input logic [31:0] a, input logic [15:0] s,
                           input int stall_pct, input int stall_first);
        int cyc        = 0;
        bit fin        = 0;
        int stall_left = stall_first;
        chk("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        axready   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_size  = 16'($urandom);
        while (!fin && cyc <= 3000) begin
            chk("axvalid", 32'(axvalid), 32'(exp_addr_q.size() != 0));
            chk("done", 32'(done), 32'(exp_addr_q.size() == 0));
            if (exp_addr_q.size() == 0) begin
                chk("req_ready_at_done", 32'(req_ready), 32'd1);
                fin = 1;
            end else if (axvalid) begin
                chk("axaddr", axaddr, exp_addr_q[0]);
                chk("axlen", 32'(axlen), 32'(exp_len_q[0]));
                chk("axsize", 32'(axsize), 32'd2);
                chk("axburst", 32'(axburst), 32'd1);
                if (stall_left > 0) begin
                    axready = 1'b0;
                    stall_left--;
                end else begin
                    axready = ($urandom_range(99) >= stall_pct);
                end
                if (axready) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_len_q.pop_front());
                end
            end else begin
                fin = 1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        assert (fin) else begin
            errors++;
            $error("FAIL timeout: observed cycles=%0d expected done within 3000", cyc);
        end
        axready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        exp_addr_q.delete();
        exp_len_q.delete();
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rs;

        // Reset state while rst is held.
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_axvalid", 32'(axvalid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_axaddr", axaddr, 32'd0);
        chk("rst_axlen", 32'(axlen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single full burst.
        exp_addr_q.push_back(32'h1000); exp_len_q.push_back(8'd15);
        run_req(32'h1000, 16'd64, 0, 0);

        // Two bursts back-to-back.
        exp_addr_q.push_back(32'h1000); exp_len_q.push_back(8'd15);
        exp_addr_q.push_back(32'h1040); exp_len_q.push_back(8'd8);
        run_req(32'h1000, 16'd100, 0, 0);

        // Request straddling a 4KB boundary.
`ifdef MUNOC_BURST_SPLIT_4KB_EN
        exp_addr_q.push_back(32'h0FF0); exp_len_q.push_back(8'd3);
        exp_addr_q.push_back(32'h1000); exp_len_q.push_back(8'd3);
`else
        exp_addr_q.push_back(32'h0FF0); exp_len_q.push_back(8'd7);
`endif
        run_req(32'h0FF0, 16'd32, 0, 0);

        // Five cycles of back-pressure on the first command.
        exp_addr_q.push_back(32'h2000); exp_len_q.push_back(8'd15);
        run_req(32'h2000, 16'd64, 0, 5);

        // Zero-length request.
        run_req(32'h3000, 16'd0, 0, 0);

        // Unaligned start address and address wrap at the top of memory.
        model_split(32'h0000_5003, 16'd20);
        run_req(32'h0000_5003, 16'd20, 0, 0);
        model_split(32'hFFFF_FFF0, 16'd64);
        run_req(32'hFFFF_FFF0, 16'd64, 30, 0);

        // Reset during the second burst of the two-burst request.
        req_valid = 1'b1; req_addr = 32'h1000; req_size = 16'd100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_first_addr", axaddr, 32'h1000);
        chk("mid_first_len", 32'(axlen), 32'd15);
        axready = 1'b1;
        @(negedge clk);
        axready = 1'b0;
        chk("mid_second_valid", 32'(axvalid), 32'd1);
        chk("mid_second_addr", axaddr, 32'h1040);
        chk("mid_second_len", 32'(axlen), 32'd8);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_axvalid", 32'(axvalid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_axaddr", axaddr, 32'd0);
        chk("mid_rst_axlen", 32'(axlen), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_axvalid", 32'(axvalid), 32'd0);
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        end

        // Randomized requests against the reference split.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(2))
                0: ra = (ra & 32'hFFFF_F000) | (32'h0000_0F00 + 32'($urandom_range(255)));
                1: ra = 32'hFFFF_FF00 | 32'($urandom_range(255));
                default: ;
            endcase
            rs = 16'($urandom_range(200) * 4);
            model_split(ra, rs);
            run_req(ra, rs, int'($urandom_range(50)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
